// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the product-to-BCD converter.
package product_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Handshake/result bundle between the multiplier, the converter and the display driver.
// digit_en is present only when BCD_BLANK_EN is defined.
interface product_bcd_converter_if #(
    parameter int WIDTH  = product_bcd_pkg::DEF_WIDTH,
    parameter int DIGITS = product_bcd_pkg::DEF_DIGITS
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     digit_en;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, bcd, busy, digit_en
    );
    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, bcd, busy, digit_en
    );
`else
    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, bcd, busy
    );
    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, bcd, busy
    );
`endif
endinterface

// File: rtl/product_bcd_converter_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adjust
    import product_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    // din <= 9 on every use, so the 4-bit sum never wraps.
    assign dout = (din >= ADJ_THRESHOLD) ? din + ADJ_ADD : din;
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a held result.
// Define BCD_BLANK_EN to add the leading-zero blanking mask digit_en.
module product_bcd_converter
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    product_bcd_converter_if.slave  bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + WIDTH;
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORK_W-1:0]       work_q, work_d;
    logic [WORK_W-1:0]       work_adj, work_shift;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [DIGITS-1:0][3:0]  digit_cur, digit_adj;
    logic                    last_shift;

    assign digit_cur = work_q[WORK_W-1:WIDTH];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (digit_cur[g]),
            .dout (digit_adj[g])
        );
    end

    // Adjust first, then shift; the binary MSB falls into the ones digit.
    assign work_adj   = {digit_adj, work_q[WIDTH-1:0]};
    assign work_shift = {work_adj[WORK_W-2:0], 1'b0};
    assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]       den_q, den_d, den_calc;
    logic [DIGITS-1:0][3:0]  res_digits;
    logic                    nz;

    assign res_digits = work_shift[WORK_W-1:WIDTH];

    always_comb begin
        den_calc = '0;
        nz       = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz          = nz | (res_digits[i] != 4'd0);
            den_calc[i] = nz;
        end
        den_calc[0] = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
`ifdef BCD_BLANK_EN
            den_q   <= DIGITS'(1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
`ifdef BCD_BLANK_EN
            den_q   <= den_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (last_shift)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath next values; bcd/digit_en only move on the DONE-entry edge.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
`ifdef BCD_BLANK_EN
        den_d  = den_q;
`endif
        if (state_q == IDLE && bus.in_valid) begin
            work_d = {{BCD_W{1'b0}}, bus.in_bin};
            cnt_d  = '0;
        end else if (state_q == SHIFT) begin
            work_d = work_shift;
            cnt_d  = cnt_q + 1'b1;
            if (last_shift) begin
                bcd_d = work_shift[WORK_W-1:WIDTH];
`ifdef BCD_BLANK_EN
                den_d = den_calc;
`endif
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q == SHIFT);
        bus.bcd       = bcd_q;
`ifdef BCD_BLANK_EN
        bus.digit_en  = den_q;
`endif
    end

endmodule
